// File: rtl/fifo_ms_ctrl.sv
// rtl/fifo_ms_ctrl.sv - multi-stream tagged FIFO: FLUX circular queues in one array,
// routed by write tag, with per-channel count, almost_full, flush and sticky error flags.
module fifo_ms_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int FLUX       = 2,
   parameter int AF_MARGIN  = 1,
   parameter int TAG_WIDTH  = $clog2(FLUX),
   parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH,
   parameter int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_din,
   input  logic [FLUX-1:0]       rd_en,
   output logic [WIDTH-1:0]      rd_dout,
   input  logic [FLUX-1:0]       flush,
   input  logic                  err_clr,
   output logic [FLUX-1:0]       full,
   output logic [FLUX-1:0]       empty,
   output logic [FLUX-1:0]       almost_full,
   output logic [FLUX*CNT_W-1:0] count,
   output logic [FLUX-1:0]       overflow,
   output logic [FLUX-1:0]       underflow,
   output logic                  bad_tag
);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int MEM_N  = FLUX * DEPTH;
   localparam int MEM_AW = $clog2(MEM_N);

   logic [WIDTH-1:0] mem [MEM_N];

   logic [FLUX-1:0][PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [FLUX-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [FLUX-1:0]            ovf_q, ovf_d, udf_q, udf_d;
   logic                       bad_q, bad_d;

   logic [TAG_WIDTH-1:0] tag, sel;
   logic                 tag_ok, rd_any;
   logic [FLUX-1:0]      wr_go, pop_go;
   logic [MEM_AW-1:0]    waddr, raddr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign tag    = wr_din[WIDTH-1 -: TAG_WIDTH];
   assign tag_ok = {1'b0, tag} < (TAG_WIDTH + 1)'(FLUX);

   // Lowest set rd_en bit wins; channel 0 drives rd_dout when nothing is requested.
   always_comb begin
      sel    = '0;
      rd_any = 1'b0;
      for (int c = FLUX - 1; c >= 0; c--) begin
         if (rd_en[c]) begin
            sel    = TAG_WIDTH'(c);
            rd_any = 1'b1;
         end
      end
   end

   always_comb begin
      wr_go  = '0;
      pop_go = '0;
      ovf_d  = ovf_q & ~{FLUX{err_clr}};
      udf_d  = udf_q & ~{FLUX{err_clr}};
      bad_d  = (bad_q & ~err_clr) | (wr_en & ~tag_ok);
      wp_d   = wp_q;
      rp_d   = rp_q;
      cnt_d  = cnt_q;
      for (int c = 0; c < FLUX; c++) begin
         // Flush swallows any same-cycle traffic on its channel without raising flags.
         if (!flush[c]) begin
            if (rd_any && sel == TAG_WIDTH'(c)) begin
               if (cnt_q[c] != '0) pop_go[c] = 1'b1;
               else                udf_d[c]  = 1'b1;
            end
            if (wr_en && tag_ok && tag == TAG_WIDTH'(c)) begin
               if (cnt_q[c] != CNT_W'(DEPTH) || pop_go[c]) wr_go[c] = 1'b1;
               else                                        ovf_d[c] = 1'b1;
            end
         end
         if (flush[c]) begin
            wp_d[c]  = '0;
            rp_d[c]  = '0;
            cnt_d[c] = '0;
         end else begin
            if (wr_go[c])  wp_d[c] = ptr_inc(wp_q[c]);
            if (pop_go[c]) rp_d[c] = ptr_inc(rp_q[c]);
            cnt_d[c] = cnt_q[c] + CNT_W'(wr_go[c]) - CNT_W'(pop_go[c]);
         end
      end
   end

   always_comb begin
      for (int c = 0; c < FLUX; c++) begin
         full[c]        = (cnt_q[c] == CNT_W'(DEPTH));
         empty[c]       = (cnt_q[c] == '0);
         almost_full[c] = (cnt_q[c] >= CNT_W'(DEPTH - AF_MARGIN));
      end
   end

   assign count     = cnt_q;
   assign overflow  = ovf_q;
   assign underflow = udf_q;
   assign bad_tag   = bad_q;

   assign waddr   = MEM_AW'(int'(tag) * DEPTH + int'(wp_q[tag]));
   assign raddr   = MEM_AW'(int'(sel) * DEPTH + int'(rp_q[sel]));
   assign rd_dout = mem[raddr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= '0;
         udf_q <= '0;
         bad_q <= 1'b0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
         bad_q <= bad_d;
      end
   end

   always_ff @(posedge clk) begin
      if (|wr_go) mem[waddr] <= wr_din;
   end
endmodule

// File: tb/tb_fifo_ms_ctrl.sv
// tb/tb_fifo_ms_ctrl.sv - scoreboard bench for fifo_ms_ctrl (2x4 and 3x5 configurations).
module tb_fifo_ms_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A: DEPTH=4, FLUX=2, AF_MARGIN=1 -> WIDTH=9, CNT_W=3
   logic       a_wr_en, a_err_clr;
   logic [8:0] a_wr_din, a_rd_dout;
   logic [1:0] a_rd_en, a_flush, a_full, a_empty, a_af, a_ov, a_uf;
   logic [5:0] a_count;
   logic       a_bt;

   // Instance B: DEPTH=5, FLUX=3, AF_MARGIN=1 -> WIDTH=10, CNT_W=3
   logic       b_wr_en, b_err_clr;
   logic [9:0] b_wr_din, b_rd_dout;
   logic [2:0] b_rd_en, b_flush, b_full, b_empty, b_af, b_ov, b_uf;
   logic [8:0] b_count;
   logic       b_bt;

   logic [7:0] a_sb0[$], a_sb1[$], b_sb0[$], b_sb1[$], b_sb2[$];
   logic [7:0] exp_d;

   fifo_ms_ctrl #(.DATA_WIDTH(8), .DEPTH(4), .FLUX(2), .AF_MARGIN(1)) dut_a (
      .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_din(a_wr_din), .rd_en(a_rd_en),
      .rd_dout(a_rd_dout), .flush(a_flush), .err_clr(a_err_clr), .full(a_full),
      .empty(a_empty), .almost_full(a_af), .count(a_count), .overflow(a_ov),
      .underflow(a_uf), .bad_tag(a_bt));

   fifo_ms_ctrl #(.DATA_WIDTH(8), .DEPTH(5), .FLUX(3), .AF_MARGIN(1)) dut_b (
      .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_din(b_wr_din), .rd_en(b_rd_en),
      .rd_dout(b_rd_dout), .flush(b_flush), .err_clr(b_err_clr), .full(b_full),
      .empty(b_empty), .almost_full(b_af), .count(b_count), .overflow(b_ov),
      .underflow(b_uf), .bad_tag(b_bt));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_write(input logic tag, input logic [7:0] d, input logic push);
      a_wr_en = 1'b1; a_wr_din = {tag, d};
      if (push) begin
         if (tag) a_sb1.push_back(d); else a_sb0.push_back(d);
      end
      tick();
      a_wr_en = 1'b0;
   endtask

   task automatic b_write(input logic [1:0] tag, input logic [7:0] d);
      b_wr_en = 1'b1; b_wr_din = {tag, d};
      if (tag == 2'd0) b_sb0.push_back(d);
      else if (tag == 2'd1) b_sb1.push_back(d);
      else if (tag == 2'd2) b_sb2.push_back(d);
      tick();
      b_wr_en = 1'b0;
   endtask

   // Pops head of channel ch on instance A, comparing the show-ahead word before the edge.
   task automatic a_pop(input logic ch, input logic [1:0] req, input string nm);
      a_rd_en = req;
      #1;
      checks++;
      if ((ch ? a_sb1.size() : a_sb0.size()) == 0) begin
         errors++;
         $display("FAIL %s scoreboard empty, rd_dout=%h", nm, a_rd_dout);
      end else begin
         exp_d = ch ? a_sb1.pop_front() : a_sb0.pop_front();
         if (a_rd_dout !== {ch, exp_d}) begin
            errors++;
            $display("FAIL %s rd_dout got %h expected %h", nm, a_rd_dout, {ch, exp_d});
         end
      end
      tick();
      a_rd_en = '0;
   endtask

   task automatic b_pop(input logic [1:0] ch, input string nm);
      b_rd_en = 3'b001 << ch;
      #1;
      checks++;
      if (ch == 2'd0) exp_d = (b_sb0.size() > 0) ? b_sb0.pop_front() : 8'hxx;
      else if (ch == 2'd1) exp_d = (b_sb1.size() > 0) ? b_sb1.pop_front() : 8'hxx;
      else exp_d = (b_sb2.size() > 0) ? b_sb2.pop_front() : 8'hxx;
      if (b_rd_dout !== {ch, exp_d}) begin
         errors++;
         $display("FAIL %s rd_dout got %h expected %h", nm, b_rd_dout, {ch, exp_d});
      end
      tick();
      b_rd_en = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
      checks++; if (a_empty !== 2'b11) begin errors++; $display("FAIL rst_a_empty got %b expected 11", a_empty); end
      checks++; if (a_full !== 2'b00 || a_af !== 2'b00) begin errors++; $display("FAIL rst_a_full_af got %b/%b expected 00/00", a_full, a_af); end
      checks++; if (a_count !== 6'd0) begin errors++; $display("FAIL rst_a_count got %h expected 0", a_count); end
      checks++; if ({a_ov, a_uf, a_bt} !== 5'd0) begin errors++; $display("FAIL rst_a_flags got %b expected 0", {a_ov, a_uf, a_bt}); end
      checks++; if (b_empty !== 3'b111 || b_count !== 9'd0) begin errors++; $display("FAIL rst_b got empty %b count %h expected 111/0", b_empty, b_count); end
   endtask

   task automatic test_fill_overflow();
      a_write(1'b0, 8'h11, 1'b1);
      checks++; if (a_count[2:0] !== 3'd1 || a_af[0] !== 1'b0) begin errors++; $display("FAIL fill1 got count %0d af %b expected 1/0", a_count[2:0], a_af[0]); end
      a_write(1'b0, 8'h22, 1'b1);
      a_write(1'b0, 8'h33, 1'b1);
      checks++; if (a_count[2:0] !== 3'd3 || a_af[0] !== 1'b1 || a_full[0] !== 1'b0) begin
         errors++; $display("FAIL fill3 got count %0d af %b full %b expected 3/1/0", a_count[2:0], a_af[0], a_full[0]); end
      a_write(1'b0, 8'h44, 1'b1);
      checks++; if (a_full[0] !== 1'b1) begin errors++; $display("FAIL fill4_full got %b expected 1", a_full[0]); end
      a_write(1'b0, 8'h55, 1'b0);
      checks++; if (a_ov !== 2'b01 || a_count[2:0] !== 3'd4) begin errors++; $display("FAIL overflow got ov %b count %0d expected 01/4", a_ov, a_count[2:0]); end
      for (int i = 0; i < 4; i++) a_pop(1'b0, 2'b01, "drain_ch0");
      checks++; if (a_empty[0] !== 1'b1) begin errors++; $display("FAIL drain_empty got %b expected 1", a_empty[0]); end
      a_err_clr = 1'b1; tick(); a_err_clr = 1'b0;
      checks++; if (a_ov !== 2'b00) begin errors++; $display("FAIL ov_clear got %b expected 00", a_ov); end
   endtask

   task automatic test_full_write_pop();
      for (int i = 1; i <= 4; i++) a_write(1'b0, 8'hA0 + 8'(i), 1'b1);
      a_wr_en = 1'b1; a_wr_din = {1'b0, 8'h66};
      a_pop(1'b0, 2'b01, "full_wr_pop_head");
      a_sb0.push_back(8'h66);
      a_wr_en = 1'b0;
      checks++; if (a_count[2:0] !== 3'd4 || a_ov !== 2'b00) begin errors++; $display("FAIL full_wr_pop got count %0d ov %b expected 4/00", a_count[2:0], a_ov); end
      for (int i = 0; i < 4; i++) a_pop(1'b0, 2'b01, "wrap_drain");
      checks++; if (a_empty[0] !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b expected 1", a_empty[0]); end
   endtask

   task automatic test_interleave();
      a_write(1'b1, 8'h0A, 1'b1);
      a_write(1'b0, 8'h05, 1'b1);
      a_write(1'b1, 8'h0B, 1'b1);
      a_pop(1'b0, 2'b11, "prio_ch0");
      checks++; if (a_count[5:3] !== 3'd2 || a_empty[0] !== 1'b1 || a_uf !== 2'b00) begin
         errors++; $display("FAIL prio_state got count1 %0d empty0 %b uf %b expected 2/1/00", a_count[5:3], a_empty[0], a_uf); end
      a_pop(1'b1, 2'b10, "ch1_first");
      a_pop(1'b1, 2'b10, "ch1_second");
      checks++; if (a_empty[1] !== 1'b1) begin errors++; $display("FAIL ch1_empty got %b expected 1", a_empty[1]); end
   endtask

   task automatic test_underflow();
      a_rd_en = 2'b10; tick(); a_rd_en = 2'b00;
      checks++; if (a_uf !== 2'b10 || a_count[5:3] !== 3'd0) begin errors++; $display("FAIL underflow got uf %b count1 %0d expected 10/0", a_uf, a_count[5:3]); end
      a_err_clr = 1'b1; tick(); a_err_clr = 1'b0;
      checks++; if (a_uf !== 2'b00) begin errors++; $display("FAIL uf_clear got %b expected 00", a_uf); end
      a_err_clr = 1'b1; a_rd_en = 2'b10; tick(); a_err_clr = 1'b0; a_rd_en = 2'b00;
      checks++; if (a_uf !== 2'b10) begin errors++; $display("FAIL uf_set_wins got %b expected 10", a_uf); end
      // empty channel with simultaneous write and pop: write lands, pop flagged
      a_wr_en = 1'b1; a_wr_din = {1'b1, 8'h77}; a_rd_en = 2'b10; a_err_clr = 1'b1;
      a_sb1.push_back(8'h77);
      tick();
      a_wr_en = 1'b0; a_rd_en = 2'b00; a_err_clr = 1'b0;
      checks++; if (a_count[5:3] !== 3'd1 || a_uf !== 2'b10) begin errors++; $display("FAIL empty_wr_pop got count1 %0d uf %b expected 1/10", a_count[5:3], a_uf); end
      a_pop(1'b1, 2'b10, "empty_wr_pop_data");
   endtask

   task automatic test_bad_tag();
      b_write(2'd3, 8'h3C);
      checks++; if (b_bt !== 1'b1 || b_count !== 9'd0 || b_ov !== 3'd0) begin
         errors++; $display("FAIL bad_tag got bt %b count %h ov %b expected 1/0/000", b_bt, b_count, b_ov); end
      b_err_clr = 1'b1; tick(); b_err_clr = 1'b0;
      checks++; if (b_bt !== 1'b0) begin errors++; $display("FAIL bad_tag_clear got %b expected 0", b_bt); end
   endtask

   task automatic test_flush();
      b_write(2'd0, 8'h50);
      b_write(2'd1, 8'h51);
      for (int i = 0; i < 3; i++) b_write(2'd2, 8'hC0 + 8'(i));
      checks++; if (b_count[8:6] !== 3'd3) begin errors++; $display("FAIL pre_flush count2 got %0d expected 3", b_count[8:6]); end
      b_flush = 3'b100; b_wr_en = 1'b1; b_wr_din = {2'd2, 8'h99}; b_rd_en = 3'b100;
      tick();
      b_flush = '0; b_wr_en = 1'b0; b_rd_en = '0;
      b_sb2.delete();
      checks++; if (b_count[8:6] !== 3'd0 || b_empty[2] !== 1'b1) begin errors++; $display("FAIL flush got count2 %0d empty2 %b expected 0/1", b_count[8:6], b_empty[2]); end
      checks++; if (b_count[5:0] !== 6'o11 || {b_ov, b_uf} !== 6'd0) begin errors++; $display("FAIL flush_others got count %h flags %b expected 011/0", b_count[5:0], {b_ov, b_uf}); end
      b_write(2'd2, 8'hAB);
      b_pop(2'd2, "post_flush_ch2");
      b_pop(2'd0, "b_ch0");
      b_pop(2'd1, "b_ch1");
   endtask

   task automatic test_reset_mid();
      b_write(2'd0, 8'hE1);
      b_write(2'd1, 8'hE2);
      a_write(1'b0, 8'hE3, 1'b1);
      rst = 1'b1; tick(); rst = 1'b0;
      b_sb0.delete(); b_sb1.delete(); a_sb0.delete();
      checks++; if (b_count !== 9'd0 || b_empty !== 3'b111) begin errors++; $display("FAIL rst_mid_b got count %h empty %b expected 0/111", b_count, b_empty); end
      checks++; if (a_count !== 6'd0 || a_empty !== 2'b11) begin errors++; $display("FAIL rst_mid_a got count %h empty %b expected 0/11", a_count, a_empty); end
   endtask

   initial begin
      rst = 1'b1;
      a_wr_en = 0; a_wr_din = '0; a_rd_en = '0; a_flush = '0; a_err_clr = 0;
      b_wr_en = 0; b_wr_din = '0; b_rd_en = '0; b_flush = '0; b_err_clr = 0;
      test_reset();
      test_fill_overflow();
      test_full_write_pop();
      test_interleave();
      test_underflow();
      test_bad_tag();
      test_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fifo_ms_ctrl.md
Name: fifo_ms_ctrl

Overview:
Multi-stream tagged FIFO, the successor to the per-flux FIFO. It holds FLUX independent circular queues in one storage array, and the tag in the top bits of the write word routes each write to its queue. Compared with the earlier block it adds:
- arbitrary (non power-of-two) DEPTH and FLUX
- a per-channel occupancy count and almost_full
- per-channel flush
- sticky overflow, underflow and bad-tag error flags

Consumers in the multi-dataflow fabric pop channels independently.

Parameters:
DATA_WIDTH, 8, payload bits per word (excluding tag)
DEPTH, 4, entries per channel, >= 2, any integer
FLUX, 2, number of channels, >= 2
AF_MARGIN, 1, almost_full asserts when count >= DEPTH-AF_MARGIN, range 0..DEPTH-1
TAG_WIDTH, $clog2(FLUX), derived, tag bits
WIDTH, DATA_WIDTH+TAG_WIDTH, derived, stored word width
CNT_W, $clog2(DEPTH+1), derived, count width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
wr_en  in  1  write strobe
wr_din  in  WIDTH  write word; tag = wr_din[WIDTH-1 -: TAG_WIDTH]
rd_en  in  FLUX  per-channel pop request
rd_dout  in/out: out  WIDTH  head word of the selected channel (show-ahead)
flush  in  FLUX  per-channel synchronous clear
err_clr  in  1  clears all sticky error flags
full  out  FLUX  channel count == DEPTH
empty  out  FLUX  channel count == 0
almost_full  out  FLUX  channel count >= DEPTH-AF_MARGIN
count  out  FLUX*CNT_W  packed per-channel occupancy; channel c at [c*CNT_W +: CNT_W]
overflow  out  FLUX  sticky: write dropped because the channel was full
underflow  out  FLUX  sticky: pop requested while the channel was empty
bad_tag  out  1  sticky: write carried a tag >= FLUX

Behaviour:
- State per channel: write pointer, read pointer (0..DEPTH-1) and a CNT_W-bit count register.
  - Pointers wrap from DEPTH-1 to 0 by explicit compare, never by natural overflow.
  - Storage is not reset.
- Reset: all pointers and counts 0, so empty=all 1, full=0, almost_full=0 (AF_MARGIN<DEPTH), count=0.
  - overflow=0, underflow=0, bad_tag=0. rd_dout is undefined until the first write.
- full, empty, almost_full and count are combinational from the count registers, so there is no extra latency beyond the count update.
- Write accepted when wr_en=1, tag<FLUX, flush[tag]=0, and either count[tag]<DEPTH or a pop of the same channel is granted that cycle.
  - Accepted write: mem[tag][wp] <= wr_din, wp advances.
  - Write to a full channel with no same-cycle pop: dropped, overflow[tag] <= 1.
  - Tag >= FLUX (only possible when FLUX is not a power of two): dropped, bad_tag <= 1.
- Pop selection:
  - The serviced channel is the lowest index set in rd_en; higher set bits are ignored that cycle, with no state change and no flag.
  - Pop is granted if count>0 and flush=0; rp then advances.
  - Pop of an empty channel: ignored, underflow[c] <= 1.
- rd_dout = mem[sel][rp[sel]]. sel is the lowest set rd_en bit, or channel 0 when rd_en==0. Data is valid when empty[sel]=0.
- Write latency: a word written at edge n is visible on rd_dout and counted after edge n (one cycle). A pop takes effect at the edge; rd_dout shows the next head after the edge.
- Count update per channel: +1 on accepted write only, -1 on granted pop only, unchanged on both or neither. It never exceeds DEPTH and never drops below 0.
- Same channel empty with simultaneous write and pop: the pop is not granted (count 0, underflow set), the write is accepted, and count becomes 1.
- flush[c]=1: at the edge wp, rp and count of channel c go to 0.
  - Flush has priority over a same-cycle write or pop to channel c; both are discarded with no error flags.
  - Other channels are unaffected.
- Error flags are sticky until err_clr=1 or rst. If err_clr and a new error occur in the same cycle, the flag ends up set (set wins).
- rst has priority over everything. Reset mid-operation discards all queued data: counts 0, empty asserted the next cycle.

Test Plan:
- Reset, then idle → empty=2'b11, full=0, count=0, all error flags 0.
- DEPTH=4, FLUX=2, AF_MARGIN=1:
  - Write tags 0,0,0 with payloads 0x11,0x22,0x33 → count0=3, almost_full[0]=1, full[0]=0.
  - 4th write 0x44 → full[0]=1.
  - 5th write 0x55 → dropped, overflow[0]=1, count0=4.
  - Pop ch0 four times → rd_dout sequence 0x11,0x22,0x33,0x44, then empty[0]=1.
- Channel 0 full, same-cycle write 0x66 (tag 0) and rd_en=2'b01 → rd_dout=head before the edge, count0 stays 4, no overflow.
  - Continue popping → 0x66 appears last (pointer wrap exercised).
- Interleaved tags: 0x0A→ch1, 0x05→ch0, 0x0B→ch1; rd_en=2'b11 → only ch0 popped (0x05); then rd_en=2'b10 → 0x0A then 0x0B; ch1 empty afterwards.
- rd_en=2'b10 on empty ch1 → underflow[1]=1, count1 stays 0. err_clr pulse → underflow cleared.
- FLUX=3, DEPTH=5:
  - Write with tag 3 → bad_tag=1, no count changes.
  - Fill ch2 with 3 words, then flush[2] together with a ch2 write → count2=0, empty[2]=1, ch0/ch1 unchanged.
  - rst mid-fill → all counts 0 the next cycle.
